mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-002 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-003 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-004 Port multiplier: input, 32 bits, two's-complement signed operand.
REQ-005 Port multiplicand: input, 32 bits, two's-complement signed operand.
REQ-006 Port op_start: input, 1 bit, level request to start an operation.
REQ-007 Port op_clear: input, 1 bit, synchronous abort/clear; returns the unit to idle.
REQ-008 Port op_done: output, 1 bit, registered; high while a completed result is held.
REQ-009 Port MUL_result: output, 64 bits, registered signed product multiplier × multiplicand.

Function
REQ-010 The unit SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-011 IDLE with op_start=1 and op_clear=0 at a rising edge SHALL capture both operands, zero the accumulator and step counter, and enter EXEC.
REQ-012 Operand changes after capture SHALL be ignored until the next capture.
REQ-013 In EXEC, each rising edge SHALL perform exactly one Booth recoding step: add 0, ±multiplicand or ±2×multiplicand (radix-4), then arithmetic-shift.
REQ-014 After the last step (16 with radix-4, 32 with radix-2), the FSM SHALL enter DONE on that same edge, with op_done=1 and MUL_result holding the final product.
REQ-015 Latency: with radix-4, op_done SHALL rise on the 16th rising edge after the capture edge; with radix-2, on the 32nd.
REQ-016 DONE SHALL persist, holding MUL_result and op_done=1, until op_clear=1. A still-high op_start SHALL NOT restart the operation.
REQ-017 op_clear=1 at a rising edge in any state SHALL set IDLE, op_done=0 and MUL_result=0 at that edge. op_clear SHALL have priority over op_start.
REQ-018 After the clear, a new operation SHALL start only when op_start=1 and op_clear=0 in IDLE.
REQ-019 During EXEC, MUL_result SHALL show the running partial accumulator. It SHALL be valid only while op_done=1.
REQ-020 The product SHALL be exact 64-bit two's complement for all operand pairs, including 0x8000_0000 × 0x8000_0000. The accumulator SHALL carry one guard bit so that ±2×multiplicand never overflows.
REQ-021 op_start=0 in IDLE SHALL keep the unit idle, with outputs unchanged at zero.

Reset
REQ-022 reset_n=0 SHALL immediately, and independent of clk, force IDLE, op_done=0, MUL_result=0, and clear the counter, accumulator and captured operands.
REQ-023 Reset asserted mid-EXEC SHALL abort the operation with no residual state. After release, the unit SHALL wait in IDLE for op_start.

Configuration
REQ-024 With macro MUL_RADIX4_EN defined, the unit SHALL use radix-4 Booth recoding: 16 EXEC steps, 2 multiplier bits retired per step.
REQ-025 Without MUL_RADIX4_EN, the unit SHALL use radix-2 Booth recoding: 32 EXEC steps, add 0 or ±multiplicand per step. Results SHALL be identical to the radix-4 build.

Structure
REQ-026 Shared package mul_pkg SHALL hold: the FSM state typedef (IDLE/EXEC/DONE), operand width 32, result width 64, and the step-count constants 16 and 32.
REQ-027 Booth digit selection SHALL live in one sub-module, mul_booth_enc. It maps the recoded multiplier bits to a selected addend (0, ±M, ±2M).

Verification
REQ-028 Case 1: reset release, then op_start=1 held, multiplier=32'h0000_003F (63), multiplicand=32'hFFFF_FFC4 (-60) -> op_done=1 after 16 cycles (radix-4), MUL_result=64'hFFFF_FFFF_FFFF_F13C (-3780), held while op_start stays high.
REQ-029 Case 2: 32'h8000_0000 × 32'h8000_0000 -> MUL_result=64'h4000_0000_0000_0000.
REQ-030 Case 3: 32'hFFFF_FFFF × 32'hFFFF_FFFF -> MUL_result=64'h1; also 0 × 32'h1234_5678 -> 0.
REQ-031 Case 4: op_clear=1 for one cycle at step 8 of EXEC -> next edge IDLE, op_done=0, MUL_result=0; a following op_start yields the correct fresh product.
REQ-032 Case 5: reset_n pulsed low mid-EXEC between clock edges -> outputs zero immediately; a restart after release produces the correct product.
REQ-033 Case 6: op_start and op_clear both high in IDLE -> unit stays IDLE.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential Booth multiplier.
// Define MUL_RADIX4_EN for radix-4 recoding; the default build uses radix-2.
package mul_pkg;

    localparam int OPW      = 32;
    localparam int RESW     = 64;
    // Wide enough for a sign-extended 2x multiplicand plus one guard bit.
    localparam int ACCW     = OPW + 2;
    localparam int STEPS_R4 = 16;
    localparam int STEPS_R2 = 32;

`ifdef MUL_RADIX4_EN
    localparam int NUM_STEPS     = STEPS_R4;
    localparam int BITS_PER_STEP = 2;
`else
    localparam int NUM_STEPS     = STEPS_R2;
    localparam int BITS_PER_STEP = 1;
`endif

    localparam int CNTW = $clog2(NUM_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_booth_enc.sv
// Booth digit selector: maps recoded multiplier bits to an addend of 0, +/-M
// or (with MUL_RADIX4_EN) +/-2M, sign-extended to the accumulator width.
module mul_booth_enc
    import mul_pkg::*;
(
    input  logic [BITS_PER_STEP:0] booth_bits,
    input  logic [OPW-1:0]         mcand,
    output logic [ACCW-1:0]        addend
);

    logic [ACCW-1:0] m_ext;

    assign m_ext = {{(ACCW-OPW){mcand[OPW-1]}}, mcand};

`ifdef MUL_RADIX4_EN
    logic [ACCW-1:0] m2_ext;

    assign m2_ext = m_ext << 1;

    // NOTE: assign every always_comb output before the case so no path leaves it unassigned (no latch).
    always_comb begin
        addend = '0;
        case (booth_bits)
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m2_ext;
            3'b100:         addend = -m2_ext;
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
    end
`else
    always_comb begin
        addend = '0;
        case (booth_bits)
            2'b01:   addend = m_ext;
            2'b10:   addend = -m_ext;
            default: addend = '0;
        endcase
    end
`endif

endmodule

// File: rtl/mul_unit.sv
// Sequential signed 32x32 Booth multiplier with IDLE/EXEC/DONE control.
// Radix-4 when MUL_RADIX4_EN is defined, radix-2 otherwise.
module mul_unit
    import mul_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic [OPW-1:0]  multiplier,
    input  logic [OPW-1:0]  multiplicand,
    input  logic            op_start,
    input  logic            op_clear,
    output logic            op_done,
    output logic [RESW-1:0] MUL_result
);

    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(NUM_STEPS - 1);

    state_t                 state, state_nxt;
    logic [ACCW-1:0]        acc;
    logic [OPW-1:0]         q;
    logic                   q_m1;
    logic [OPW-1:0]         mcand_q;
    logic [CNTW-1:0]        cnt;

    logic [ACCW-1:0]        addend;
    logic [ACCW-1:0]        sum;
    logic signed [ACCW+OPW:0] shifted;

    mul_booth_enc u_booth_enc (
        .booth_bits (({q[BITS_PER_STEP-1:0], q_m1})),
        .mcand      (mcand_q),
        .addend     (addend)
    );

    // One Booth step: add the selected digit, then shift {acc, q, q_m1} arithmetically.
    assign sum     = acc + addend;
    assign shifted = $signed({sum, q, q_m1}) >>> BITS_PER_STEP;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_start) state_nxt = EXEC;
            EXEC:    if (cnt == LAST_STEP) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (op_clear) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            mcand_q <= '0;
            cnt     <= '0;
        end else if (op_clear) begin
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            mcand_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (op_start) begin
                    acc     <= '0;
                    q       <= multiplier;
                    q_m1    <= 1'b0;
                    mcand_q <= multiplicand;
                    cnt     <= '0;
                end
                EXEC: begin
                    acc  <= shifted[ACCW+OPW:OPW+1];
                    q    <= shifted[OPW:1];
                    q_m1 <= shifted[0];
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign op_done    = (state == DONE);
    assign MUL_result = {acc[OPW-1:0], q};

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: stimulus queues expected products, a
// monitor compares product and latency whenever op_done rises.
module tb_mul_unit;
    import mul_pkg::*;

    typedef struct {
        logic [RESW-1:0] prod;
        int              start_cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [OPW-1:0]  multiplier;
    logic [OPW-1:0]  multiplicand;
    logic            op_start;
    logic            op_clear;
    logic            op_done;
    logic [RESW-1:0] MUL_result;

    exp_t sb_q[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    logic done_prev = 1'b0;

    mul_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .op_done      (op_done),
        .MUL_result   (MUL_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_done();
        int n = 0;
        while (op_done !== 1'b1 && n < NUM_STEPS + 4) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 64'(op_done), 64'd1);
    endtask

    // Full operation: capture, scramble operands, wait, check hold, clear.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        exp_t e;
        @(negedge clk);
        multiplier   = a;
        multiplicand = b;
        op_start     = 1'b1;
        @(posedge clk);
        #1;
        e.prod      = exp;
        e.start_cyc = cyc;
        sb_q.push_back(e);
        multiplier   = ~a;
        multiplicand = b ^ 32'h5A5A_A5A5;
        wait_done();
        repeat (3) begin
            @(negedge clk);
            check("hold_done", 64'(op_done), 64'd1);
            check("hold_result", MUL_result, exp);
        end
        op_clear = 1'b1;
        op_start = 1'b0;
        @(posedge clk);
        #1;
        check("clear_done", 64'(op_done), 64'd0);
        check("clear_result", MUL_result, 64'd0);
        @(negedge clk);
        op_clear = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (op_done === 1'b1 && done_prev !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("product", MUL_result, e.prod);
                    check("latency", 64'(cyc - e.start_cyc), 64'(NUM_STEPS));
                end
            end
            done_prev = op_done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        reset_n      = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        #12;
        check("reset_done", 64'(op_done), 64'd0);
        check("reset_result", MUL_result, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle without a request stays at zero.
        multiplier = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check("idle_done", 64'(op_done), 64'd0);
        check("idle_result", MUL_result, 64'd0);

        run_op(32'h0000_003F, 32'hFFFF_FFC4, 64'hFFFF_FFFF_FFFF_F13C);
        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        run_op(32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);

        // Clear at step 8 of EXEC, with op_start still high.
        @(negedge clk);
        multiplier   = 32'h1234_5678;
        multiplicand = 32'h0000_0011;
        op_start     = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        @(negedge clk);
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        check("abort_clear_done", 64'(op_done), 64'd0);
        check("abort_clear_result", MUL_result, 64'd0);
        @(negedge clk);
        op_clear = 1'b0;
        op_start = 1'b0;
        @(negedge clk);
        check("abort_idle_result", MUL_result, 64'd0);
        run_op(32'd1000, 32'd1000, 64'h0000_0000_000F_4240);

        // Asynchronous reset between edges in the middle of EXEC.
        @(negedge clk);
        multiplier   = 32'h0000_0055;
        multiplicand = 32'h0000_0033;
        op_start     = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_done", 64'(op_done), 64'd0);
        check("async_rst_result", MUL_result, 64'd0);
        op_start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_done", 64'(op_done), 64'd0);
        check("post_rst_result", MUL_result, 64'd0);
        run_op(32'hFFFF_FFF9, 32'h0000_0009, 64'hFFFF_FFFF_FFFF_FFC1);

        // op_start and op_clear together in IDLE: clear wins.
        @(negedge clk);
        multiplier   = 32'h0000_0005;
        multiplicand = 32'h0000_0007;
        op_start     = 1'b1;
        op_clear     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("both_high_done", 64'(op_done), 64'd0);
            check("both_high_result", MUL_result, 64'd0);
        end
        op_start = 1'b0;
        op_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("both_high_after", MUL_result, 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
